// File: rtl/fft_peak_analyzer.sv
// Peak-bin finder for the 16-point FFT output stream.
// Captures a frame on fft_valid, then walks the 16 bins one per cycle through a
// single squared-magnitude datapath and reports the index of the largest bin.
// Optional build macro FFT_PEAK_MAG_OUT_EN adds the max_mag output port.
module fft_peak_analyzer #(
  parameter int NBIN = 16,
  parameter int DW   = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fft_valid,
  input  logic [31:0] fft_d0,
  input  logic [31:0] fft_d1,
  input  logic [31:0] fft_d2,
  input  logic [31:0] fft_d3,
  input  logic [31:0] fft_d4,
  input  logic [31:0] fft_d5,
  input  logic [31:0] fft_d6,
  input  logic [31:0] fft_d7,
  input  logic [31:0] fft_d8,
  input  logic [31:0] fft_d9,
  input  logic [31:0] fft_d10,
  input  logic [31:0] fft_d11,
  input  logic [31:0] fft_d12,
  input  logic [31:0] fft_d13,
  input  logic [31:0] fft_d14,
  input  logic [31:0] fft_d15,
  output logic        done,
  output logic [3:0]  freq,
  output logic        overrun
`ifdef FFT_PEAK_MAG_OUT_EN
  ,
  output logic [31:0] max_mag
`endif
);

  typedef enum logic [0:0] {StIdle, StCalc} state_t;

  state_t      state_q, state_d;
  logic [3:0]  idx_q;
  logic [31:0] max_q;
  logic [3:0]  best_q;
  logic [3:0]  freq_q;
  logic        done_q;
  logic        overrun_q;
  logic [31:0] buf_q [NBIN];
  logic [31:0] frame_in [NBIN];

  logic                 load;
  logic                 last;
  logic signed [DW-1:0] re, im;
  logic signed [31:0]   re_x, im_x, re_sq, im_sq;
  logic [31:0]          mag;
  logic [31:0]          cand_max;
  logic [3:0]           cand_best;

  // Gather the flat input ports into an indexable frame.
  always_comb begin
    frame_in[0]  = fft_d0;
    frame_in[1]  = fft_d1;
    frame_in[2]  = fft_d2;
    frame_in[3]  = fft_d3;
    frame_in[4]  = fft_d4;
    frame_in[5]  = fft_d5;
    frame_in[6]  = fft_d6;
    frame_in[7]  = fft_d7;
    frame_in[8]  = fft_d8;
    frame_in[9]  = fft_d9;
    frame_in[10] = fft_d10;
    frame_in[11] = fft_d11;
    frame_in[12] = fft_d12;
    frame_in[13] = fft_d13;
    frame_in[14] = fft_d14;
    frame_in[15] = fft_d15;
  end

  assign last = (state_q == StCalc) && (idx_q == 4'(NBIN - 1));

  // Squared magnitude of the current bin and the running arg-max update.
  // Each square is at most 2^30, so the unsigned 32-bit sum cannot wrap.
  always_comb begin
    re        = buf_q[idx_q][2*DW-1:DW];
    im        = buf_q[idx_q][DW-1:0];
    re_x      = 32'(re);
    im_x      = 32'(im);
    re_sq     = re_x * re_x;
    im_sq     = im_x * im_x;
    mag       = $unsigned(re_sq) + $unsigned(im_sq);
    cand_max  = max_q;
    cand_best = best_q;
    if (idx_q == 4'd0) begin
      cand_max  = mag;
      cand_best = 4'd0;
    end else if (mag > max_q) begin
      // Strict compare keeps the lowest index on ties.
      cand_max  = mag;
      cand_best = idx_q;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Next-state logic; a frame arriving on the last bin is accepted seamlessly.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (fft_valid) begin
          load    = 1'b1;
          state_d = StCalc;
        end
      end
      StCalc: begin
        if (last) begin
          if (fft_valid) load = 1'b1;
          else           state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Frame buffer, bin walker, running max and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q     <= 4'd0;
      max_q     <= 32'd0;
      best_q    <= 4'd0;
      freq_q    <= 4'd0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
      for (int i = 0; i < NBIN; i++) buf_q[i] <= 32'd0;
    end else begin
      done_q    <= last;
      overrun_q <= (state_q == StCalc) && !last && fft_valid;
      if (state_q == StCalc) begin
        max_q  <= cand_max;
        best_q <= cand_best;
        idx_q  <= idx_q + 4'd1;
      end
      if (last) freq_q <= cand_best;
      if (load) begin
        idx_q <= 4'd0;
        for (int i = 0; i < NBIN; i++) buf_q[i] <= frame_in[i];
      end
    end
  end

`ifdef FFT_PEAK_MAG_OUT_EN
  logic [31:0] max_mag_q;

  // Winning magnitude, updated on the same edge as freq.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       max_mag_q <= 32'd0;
    else if (last) max_mag_q <= cand_max;
  end

  assign max_mag = max_mag_q;
`endif

  assign done    = done_q;
  assign freq    = freq_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_fft_peak_analyzer.sv
// Scoreboard bench for fft_peak_analyzer: a driver issues frames and pushes the
// expected report (bin index, magnitude, edge number) or overrun edge; a monitor
// pops and compares whenever done or overrun is seen.
module tb_fft_peak_analyzer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fft_valid = 1'b0;
  logic [31:0] fd [16];
  logic        done;
  logic [3:0]  freq;
  logic        overrun;
`ifdef FFT_PEAK_MAG_OUT_EN
  logic [31:0] max_mag;
`endif

  typedef struct {
    logic [3:0]  f;
    logic [31:0] m;
    int          c;
  } exp_t;

  exp_t exp_q[$];
  int   ovr_q[$];
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   have_start = 0;
  int   start_edge = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  fft_peak_analyzer dut (
    .clk(clk), .rst(rst), .fft_valid(fft_valid),
    .fft_d0(fd[0]), .fft_d1(fd[1]), .fft_d2(fd[2]), .fft_d3(fd[3]),
    .fft_d4(fd[4]), .fft_d5(fd[5]), .fft_d6(fd[6]), .fft_d7(fd[7]),
    .fft_d8(fd[8]), .fft_d9(fd[9]), .fft_d10(fd[10]), .fft_d11(fd[11]),
    .fft_d12(fd[12]), .fft_d13(fd[13]), .fft_d14(fd[14]), .fft_d15(fd[15]),
    .done(done), .freq(freq), .overrun(overrun)
`ifdef FFT_PEAK_MAG_OUT_EN
    , .max_mag(max_mag)
`endif
  );

  function automatic logic [31:0] bin(input int re, input int im);
    return {re[15:0], im[15:0]};
  endfunction

  task automatic check(input string name, input longint act, input longint req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: argmax of re^2+im^2 over the frame, lowest index on ties.
  task automatic issue();
    int     e;
    longint best_m, m, re, im;
    int     best_i;
    exp_t   x;
    e = cyc + 1;
    fft_valid = 1'b1;
    if (have_start == 0 || e >= start_edge + 16) begin
      best_m = -1;
      best_i = 0;
      for (int k = 0; k < 16; k++) begin
        re = longint'($signed(fd[k][31:16]));
        im = longint'($signed(fd[k][15:0]));
        m  = re * re + im * im;
        if (m > best_m) begin
          best_m = m;
          best_i = k;
        end
      end
      x.f = 4'(best_i);
      x.m = 32'(best_m);
      x.c = e + 16;
      exp_q.push_back(x);
      have_start = 1;
      start_edge = e;
    end else begin
      ovr_q.push_back(e);
    end
    @(negedge clk);
    fft_valid = 1'b0;
  endtask

  task automatic fill_const(input int re, input int im);
    for (int k = 0; k < 16; k++) fd[k] = bin(re, im);
  endtask

  task automatic fill_rand();
    int narrow;
    narrow = int'($urandom_range(0, 1));
    for (int k = 0; k < 16; k++) begin
      if (narrow != 0) fd[k] = bin(int'($urandom_range(0, 6)) - 3, int'($urandom_range(0, 6)) - 3);
      else             fd[k] = $urandom;
    end
  endtask

  // Monitor: compare every done/overrun against the scoreboard.
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (exp_q.size() > 0 && cyc > exp_q[0].c) begin
          x = exp_q.pop_front();
          check("missing_done", 0, 1);
        end
        if (done) begin
          if (exp_q.size() == 0) begin
            check("unexpected_done", 1, 0);
          end else begin
            x = exp_q.pop_front();
            check("done_cycle", cyc, x.c);
            check("freq", freq, x.f);
`ifdef FFT_PEAK_MAG_OUT_EN
            check("max_mag", max_mag, x.m);
`endif
          end
        end
        if (ovr_q.size() > 0 && cyc > ovr_q[0]) begin
          void'(ovr_q.pop_front());
          check("missing_overrun", 0, 1);
        end
        if (overrun) begin
          if (ovr_q.size() == 0) check("unexpected_overrun", 1, 0);
          else                   check("overrun_cycle", cyc, ovr_q.pop_front());
        end
      end
    end
  end

  task automatic do_reset();
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_done", done, 0);
    check("rst_freq", freq, 0);
    check("rst_overrun", overrun, 0);
`ifdef FFT_PEAK_MAG_OUT_EN
    check("rst_max_mag", max_mag, 0);
`endif
    exp_q.delete();
    ovr_q.delete();
    have_start = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < 16; k++) fd[k] = 32'd0;
    #1;
    check("init_done", done, 0);
    check("init_freq", freq, 0);
    check("init_overrun", overrun, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Single peak at bin 5.
    fill_const(0, 0);
    fd[5] = bin(100, -100);
    issue();
    repeat (20) @(negedge clk);

    // Tie between bins 3 and 12.
    fill_const(1, 1);
    fd[3]  = bin(300, 400);
    fd[12] = bin(300, 400);
    issue();
    repeat (20) @(negedge clk);

    // Extremes: 2^31 must not wrap.
    fill_const(0, 0);
    fd[0]  = bin(32767, 0);
    fd[15] = bin(-32768, -32768);
    issue();
    repeat (20) @(negedge clk);

    // All-zero frame.
    fill_const(0, 0);
    issue();
    repeat (20) @(negedge clk);

    // Back-to-back frames every 16 cycles.
    for (int p = 0; p < 3; p++) begin
      fill_const(2, -2);
      fd[p == 0 ? 2 : (p == 1 ? 9 : 14)] = bin(-500, 20);
      issue();
      repeat (15) @(negedge clk);
    end
    repeat (20) @(negedge clk);

    // Early second frame is dropped.
    fill_const(0, 0);
    fd[7] = bin(50, 50);
    issue();
    repeat (3) @(negedge clk);
    fd[7] = bin(0, 0);
    fd[1] = bin(9000, 9000);
    issue();
    repeat (20) @(negedge clk);

    // Reset mid-frame, then a normal frame.
    fill_const(0, 0);
    fd[10] = bin(-7, 3);
    issue();
    repeat (6) @(negedge clk);
    do_reset();
    repeat (20) @(negedge clk);
    fill_const(1, 0);
    fd[4] = bin(0, 1000);
    issue();
    repeat (20) @(negedge clk);

    // Random frames with random spacing (early, back-to-back or idle).
    for (int t = 0; t < 40; t++) begin
      fill_rand();
      issue();
      repeat ($urandom_range(0, 22)) @(negedge clk);
    end
    repeat (25) @(negedge clk);

    check("pending_done", exp_q.size(), 0);
    check("pending_overrun", ovr_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
